// File: rtl/usb_uart_pkg.sv
// usb_uart_pkg: shared definitions for the USB-serial port.
//   ST_*       bit positions inside the CPU status byte
//   serState_t 2-bit state encoding used by both the TX and RX engines
package usb_uart_pkg;

  localparam int ST_RXAVAIL = 0;
  localparam int ST_TXREADY = 1;
  localparam int ST_OVERRUN = 2;
  localparam int ST_FRAMERR = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } serState_t;

endpackage

// File: rtl/usb_uart_port_if.sv
// usb_uart_port_if: CPU-side I/O bus of the USB-serial port.
//   usbst_cs   status-port read select (port 0x34)
//   usbrxd_cs  RX-data read select (port 0x35)
//   usbtxd_cs  TX-data write select (port 0x35)
//   cpu_dout   CPU write data, valid while usbtxd_cs is high
//   data_out   byte returned to the CPU read mux
// master = CPU / port decoder side, slave = the port itself.
interface usb_uart_port_if;

  logic       usbst_cs;
  logic       usbrxd_cs;
  logic       usbtxd_cs;
  logic [7:0] cpu_dout;
  logic [7:0] data_out;

  modport master (
    output usbst_cs, usbrxd_cs, usbtxd_cs, cpu_dout,
    input  data_out
  );

  modport slave (
    input  usbst_cs, usbrxd_cs, usbtxd_cs, cpu_dout,
    output data_out
  );

endinterface

// File: rtl/usb_rx_fifo.sv
// usb_rx_fifo: synchronous byte FIFO for received serial data.
//   clock, reset_n  system clock, async active-low reset
//   push, pushData  write request and byte
//   pop             read request (ignored while empty)
//   head            byte at the read pointer (show-ahead)
//   empty, full     occupancy flags
// A push while full is accepted only when a pop happens in the same cycle;
// the freed slot is the one being written, so the count stays unchanged.
module usb_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       push,
  input  logic [7:0] pushData,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0]   count;
  logic          doPush;
  logic          doPop;

  assign empty  = (count == '0);
  assign full   = (count == CNT_FULL);
  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);
  assign head   = mem[rdPtr];

  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/usb_uart_port.sv
// usb_uart_port: byte-wide USB-serial port (status 0x34, data 0x35).
//   clock, reset_n  system clock, async active-low reset
//   bus             CPU I/O bus (usb_uart_port_if.slave)
//   usb_rxd         serial input from the bridge, asynchronous, idle high
//   usb_txd         serial output to the bridge, idle high
//
// Both engines share one encoding:
//   state | meaning
//   IDLE  | line idle; TX waits for a full holding register, RX for a falling edge
//   START | start bit; TX drives low, RX verifies low at mid-bit
//   DATA  | 8 data bits, LSB first
//   STOP  | stop bit; TX drives high, RX checks it and pushes or flags
module usb_uart_port
  import usb_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int RX_DEPTH     = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  usb_uart_port_if.slave  bus,
  input  logic            usb_rxd,
  output logic            usb_txd
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

  // select edge detection: one access per assertion
  logic stQ, rxQ, txQ;
  logic stFall, rxFall, txRise;

  assign stFall = ~bus.usbst_cs  & stQ;
  assign rxFall = ~bus.usbrxd_cs & rxQ;
  assign txRise =  bus.usbtxd_cs & ~txQ;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stQ <= 1'b0;
      rxQ <= 1'b0;
      txQ <= 1'b0;
    end else begin
      stQ <= bus.usbst_cs;
      rxQ <= bus.usbrxd_cs;
      txQ <= bus.usbtxd_cs;
    end
  end

  // transmitter
  serState_t     txState;
  logic [TW-1:0] txTimer;
  logic [2:0]    txBit;
  logic [7:0]    txShift;
  logic [7:0]    holdReg;
  logic          holdFull;
  logic          txLoad;

  // holding register drains into the shifter from IDLE or at the end of STOP
  assign txLoad = holdFull &&
                  (txState == IDLE || (txState == STOP && txTimer == '0));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      txState  <= IDLE;
      txTimer  <= '0;
      txBit    <= '0;
      txShift  <= '0;
      holdReg  <= '0;
      holdFull <= 1'b0;
      usb_txd  <= 1'b1;
    end else begin
      if (txLoad) begin
        holdFull <= 1'b0;
      end else if (txRise && !holdFull) begin
        holdReg  <= bus.cpu_dout;
        holdFull <= 1'b1;
      end

      case (txState)
        IDLE: begin
          if (txLoad) begin
            txShift <= holdReg;
            txTimer <= BIT_LAST;
            txState <= START;
          end
        end
        START: begin
          if (txTimer == '0) begin
            txTimer <= BIT_LAST;
            txBit   <= 3'd7;
            txState <= DATA;
          end else begin
            txTimer <= txTimer - 1'b1;
          end
        end
        DATA: begin
          if (txTimer == '0) begin
            txTimer <= BIT_LAST;
            txShift <= txShift >> 1;
            if (txBit == '0) txState <= STOP;
            else             txBit   <= txBit - 1'b1;
          end else begin
            txTimer <= txTimer - 1'b1;
          end
        end
        STOP: begin
          if (txTimer == '0) begin
            if (txLoad) begin
              txShift <= holdReg;
              txTimer <= BIT_LAST;
              txState <= START;
            end else begin
              txState <= IDLE;
            end
          end else begin
            txTimer <= txTimer - 1'b1;
          end
        end
        default: txState <= IDLE;
      endcase

      // line register follows the state one cycle later; every bit keeps its full width
      usb_txd <= (txState == START) ? 1'b0 :
                 (txState == DATA)  ? txShift[0] : 1'b1;
    end
  end

  // receiver
  serState_t     rxState;
  logic [TW-1:0] rxTimer;
  logic [2:0]    rxBit;
  logic [7:0]    rxShift;
  logic          rxS1, rxS2, rxLast;
  logic          rxPush, rxErrSet;
  logic [7:0]    fifoHead;
  logic          fifoEmpty, fifoFull;

  assign rxPush   = (rxState == STOP) && (rxTimer == '0) &&  rxS2;
  assign rxErrSet = (rxState == STOP) && (rxTimer == '0) && !rxS2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rxS1    <= 1'b1;
      rxS2    <= 1'b1;
      rxLast  <= 1'b1;
      rxState <= IDLE;
      rxTimer <= '0;
      rxBit   <= '0;
      rxShift <= '0;
    end else begin
      rxS1   <= usb_rxd;
      rxS2   <= rxS1;
      rxLast <= rxS2;

      case (rxState)
        IDLE: begin
          if (rxLast && !rxS2) begin
            rxTimer <= HALF_LAST;
            rxState <= START;
          end
        end
        START: begin
          if (rxTimer == '0) begin
            if (rxS2) begin
              rxState <= IDLE;
            end else begin
              rxTimer <= BIT_LAST;
              rxBit   <= 3'd7;
              rxState <= DATA;
            end
          end else begin
            rxTimer <= rxTimer - 1'b1;
          end
        end
        DATA: begin
          if (rxTimer == '0) begin
            rxShift <= {rxS2, rxShift[7:1]};
            rxTimer <= BIT_LAST;
            if (rxBit == '0) rxState <= STOP;
            else             rxBit   <= rxBit - 1'b1;
          end else begin
            rxTimer <= rxTimer - 1'b1;
          end
        end
        STOP: begin
          if (rxTimer == '0) rxState <= IDLE;
          else               rxTimer <= rxTimer - 1'b1;
        end
        default: rxState <= IDLE;
      endcase
    end
  end

  usb_rx_fifo #(.DEPTH(RX_DEPTH)) rxFifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (rxPush),
    .pushData (rxShift),
    .pop      (rxFall),
    .head     (fifoHead),
    .empty    (fifoEmpty),
    .full     (fifoFull)
  );

  // sticky errors; a new error in the clearing cycle wins
  logic overrun, framErr;
  logic ovSet;

  // full implies non-empty, so a read fall always frees a slot here
  assign ovSet = rxPush && fifoFull && !rxFall;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
      framErr <= 1'b0;
    end else begin
      if (ovSet)       overrun <= 1'b1;
      else if (stFall) overrun <= 1'b0;
      if (rxErrSet)    framErr <= 1'b1;
      else if (stFall) framErr <= 1'b0;
    end
  end

  logic [7:0] statusByte;

  always_comb begin
    statusByte             = '0;
    statusByte[ST_RXAVAIL] = ~fifoEmpty;
    statusByte[ST_TXREADY] = ~holdFull;
    statusByte[ST_OVERRUN] = overrun;
    statusByte[ST_FRAMERR] = framErr;
  end

  always_comb begin
    bus.data_out = 8'h00;
    if (bus.usbst_cs)                     bus.data_out = statusByte;
    else if (bus.usbrxd_cs && !fifoEmpty) bus.data_out = fifoHead;
  end

endmodule

// File: tb/tb_usb_uart_port.sv
module tb_usb_uart_port;

  localparam int CPB   = 8;
  localparam int DEPTH = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic usb_rxd = 1'b1;
  logic usb_txd;

  usb_uart_port_if bus();

  usb_uart_port #(.CLKS_PER_BIT(CPB), .RX_DEPTH(DEPTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .usb_rxd (usb_rxd),
    .usb_txd (usb_txd)
  );

  always #5 clock = ~clock;

  int cycleCnt = 0;
  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  int nChecks = 0;
  int nErrors = 0;
  int rstCount = 0;

  typedef struct {
    logic [7:0] data;
    int         start;
  } txExp_t;

  logic [7:0] readQ[$];
  txExp_t     txQ[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  task automatic flagError(input string name);
    nChecks++;
    nErrors++;
    $display("FAIL %s (cycle %0d)", name, cycleCnt);
  endtask

  // read scoreboard: compare data_out against the queued expectation every
  // cycle a read select is high; retire the entry when the select drops
  initial begin
    logic active;
    active = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.usbst_cs || bus.usbrxd_cs) begin
        if (readQ.size() == 0) flagError("unexpected_read");
        else                   check("read_data", bus.data_out, readQ[0]);
        active = 1'b1;
      end else begin
        if (active && readQ.size() > 0) void'(readQ.pop_front());
        active = 1'b0;
        check("idle_data_out", bus.data_out, 8'h00);
      end
    end
  end

  // serial line monitor: decode every frame on usb_txd and retire one expectation
  initial begin
    logic       prev, startOk, stopOk;
    logic [7:0] d;
    int         st, rc;
    txExp_t     e;
    prev = 1'b1;
    forever begin
      @(negedge clock);
      if (prev && !usb_txd && reset_n) begin
        st = cycleCnt;
        rc = rstCount;
        repeat (3) @(negedge clock);
        startOk = ~usb_txd;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clock);
          d[i] = usb_txd;
        end
        repeat (CPB) @(negedge clock);
        stopOk = usb_txd;
        if (rc == rstCount) begin
          if (txQ.size() == 0) begin
            flagError("unexpected_tx_frame");
          end else begin
            e = txQ.pop_front();
            check("tx_data", d, e.data);
            check("tx_start_bit", startOk, 1'b1);
            check("tx_stop_bit", stopOk, 1'b1);
            if (e.start >= 0) check("tx_start_cycle", st, e.start);
          end
        end
      end
      prev = usb_txd;
    end
  end

  task automatic cpuWrite(input logic [7:0] d, output int wEdge);
    @(posedge clock); #1;
    bus.usbtxd_cs = 1'b1;
    bus.cpu_dout  = d;
    @(posedge clock); #1;
    wEdge = cycleCnt;
    repeat (2) @(posedge clock); #1;
    bus.usbtxd_cs = 1'b0;
    bus.cpu_dout  = 8'h00;
  endtask

  task automatic cpuRead(input bit isStatus, input logic [7:0] exp);
    @(posedge clock); #1;
    readQ.push_back(exp);
    if (isStatus) bus.usbst_cs  = 1'b1;
    else          bus.usbrxd_cs = 1'b1;
    repeat (3) @(posedge clock); #1;
    bus.usbst_cs  = 1'b0;
    bus.usbrxd_cs = 1'b0;
  endtask

  task automatic bitTime(input logic v);
    usb_rxd = v;
    repeat (CPB) @(posedge clock);
    #1;
  endtask

  task automatic rxSend(input logic [7:0] d, input logic stopBit);
    @(posedge clock); #1;
    bitTime(1'b0);
    for (int i = 0; i < 8; i++) bitTime(d[i]);
    bitTime(stopBit);
    usb_rxd = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, w2, w3, lows;
    bus.usbst_cs  = 1'b0;
    bus.usbrxd_cs = 1'b0;
    bus.usbtxd_cs = 1'b0;
    bus.cpu_dout  = 8'h00;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // reset state
    check("reset_txd", usb_txd, 1'b1);
    cpuRead(1, 8'h02);
    cpuRead(0, 8'h00);

    // single frame 0xA5, start bit exactly 2 edges after the write edge
    cpuWrite(8'hA5, w);
    txQ.push_back('{8'hA5, w + 2});
    cpuRead(1, 8'h02);
    idle(100);

    // back-to-back 0x55, 0xAA; third write lands on a full holding register
    cpuWrite(8'h55, w);
    txQ.push_back('{8'h55, w + 2});
    cpuWrite(8'hAA, w2);
    txQ.push_back('{8'hAA, w + 2 + 10 * CPB});
    cpuRead(1, 8'h00);
    cpuWrite(8'hC3, w3);
    idle(300);

    // single received byte
    rxSend(8'h3C, 1'b1);
    idle(4 * CPB);
    cpuRead(1, 8'h03);
    cpuRead(0, 8'h3C);
    cpuRead(1, 8'h02);

    // overflow: 17 bytes into a 16-deep FIFO
    for (int i = 0; i <= 16; i++) rxSend(8'(i), 1'b1);
    idle(4 * CPB);
    cpuRead(1, 8'h07);
    cpuRead(1, 8'h03);
    for (int i = 0; i < 16; i++) cpuRead(0, 8'(i));
    cpuRead(0, 8'h00);
    cpuRead(1, 8'h02);

    // framing error, then a short glitch
    rxSend(8'h5A, 1'b0);
    idle(4 * CPB);
    cpuRead(1, 8'h0A);
    cpuRead(0, 8'h00);
    cpuRead(1, 8'h02);
    @(posedge clock); #1 usb_rxd = 1'b0;
    repeat (3) @(posedge clock);
    #1 usb_rxd = 1'b1;
    idle(4 * CPB);
    cpuRead(1, 8'h02);

    // reset in the middle of data bit 4 of 0x0F
    cpuWrite(8'h0F, w);
    idle(44);
    check("txd_bit4_low", usb_txd, 1'b0);
    reset_n = 1'b0;
    rstCount++;
    #1;
    check("reset_txd_async", usb_txd, 1'b1);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    cpuRead(1, 8'h02);
    lows = 0;
    repeat (150) begin
      @(negedge clock);
      if (!usb_txd) lows++;
    end
    check("no_frame_after_reset", lows, 0);

    idle(4);
    check("tx_frames_pending", txQ.size(), 0);
    check("reads_pending", readQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/usb_uart_port.md
# usb_uart_port

Byte-wide USB-serial port serving I/O ports 0x34 (status, read) and 0x35 (RX data read / TX data write), driven directly by the port decoder's `inUSBst_cs`, `inusbRxD_cs` and `outusbTxD_cs` chip selects. It serializes CPU writes onto the USB bridge TXD line, deserializes the bridge RXD line into a small receive FIFO, and presents status/data bytes to the CPU data-in mux. All logic runs in the system clock domain.

## Interface
- CLKS_PER_BIT, 434, system clocks per serial bit (50 MHz / 115200); minimum 4
- RX_DEPTH, 16, receive FIFO depth in bytes; power of two, 2–64

One clock; reset is asynchronous and active-low.
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- usbst_cs  in  1  status-port read select, active high, held for the whole I/O cycle
- usbrxd_cs  in  1  RX-data read select, active high, held for the whole I/O cycle
- usbtxd_cs  in  1  TX-data write select, active high, held for the whole I/O cycle
- cpu_dout  in  8  CPU write data, valid while usbtxd_cs is high
- data_out  out  8  byte to CPU read mux; 8'h00 when no read select is active
- usb_rxd  in  1  serial input from bridge, asynchronous, idle high
- usb_txd  out  1  serial output to bridge, idle high

## Operation
- Select edges: each select is registered once; rise = cs & ~cs_q, fall = ~cs & cs_q. Each assertion is exactly one access regardless of its length.
- Status byte: bit0 RX_AVAIL (FIFO not empty), bit1 TX_READY (holding register empty), bit2 RX_OVERRUN (sticky), bit3 RX_FRAMERR (sticky), bits7:4 = 0.
- Status read: data_out = status while usbst_cs high. On the usbst_cs fall, clear OVERRUN and FRAMERR, unless a new error sets in the same cycle (set wins).
- RX data read: data_out = FIFO head while usbrxd_cs high (8'h00 if empty). Pop on the usbrxd_cs fall so data stays stable for the whole cycle. Reading an empty FIFO returns 8'h00, with no pop and no flag change.
- TX write: on the usbtxd_cs rise, if the holding register is empty, load cpu_dout and mark it full. If it is already full, the write is dropped with no flag.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: when holding is full, move the byte to the shifter, empty holding, go to START.
  - START, DATA, STOP: each lasts CLKS_PER_BIT cycles.
  - Data bits are sent LSB first.
  - STOP then returns to IDLE, or goes straight to START if holding is full, giving back-to-back frames with no idle gap.
- RX path: usb_rxd passes through a 2-flop synchronizer.
- RX FSM (IDLE, START, DATA, STOP):
  - IDLE: the synchronized falling edge enters START.
  - START: sample at CLKS_PER_BIT/2. If the line is high, treat it as a glitch and return to IDLE.
  - DATA: sample 8 bits at CLKS_PER_BIT intervals, LSB first.
  - STOP: sample the stop bit. High means push the byte; low means set FRAMERR and discard the byte. Then return to IDLE.
- FIFO push when full: drop the byte and set OVERRUN. A push and pop in the same cycle on a full FIFO both succeed (count unchanged, no overrun). A push on empty with a simultaneous read-fall: the pop is ignored because the FIFO was empty at evaluation.
- Pointers are log2(RX_DEPTH) bits and wrap naturally. The count is log2(RX_DEPTH)+1 bits.

## Timing
- Reset values:
  - usb_txd = 1, data_out = 8'h00.
  - Both FSMs in IDLE; FIFO empty; holding register empty; flags cleared; cs_q registers 0.
- Reset asserted mid-frame aborts immediately (txd high asynchronously). The partial RX byte is lost.
- data_out is combinational from registers and selects: valid in the same cycle the select is high.
- Write to idle transmitter: holding loads at the first edge with usbtxd_cs=1. usb_txd goes low exactly 2 clock edges after that edge.
- Frame length: 10·CLKS_PER_BIT cycles. TX_READY reasserts when the byte moves to the shifter (START entry), not at frame end.
- RX: byte visible (RX_AVAIL=1) 1 cycle after the stop-bit sample, about 9.5 bit times after the start edge plus 2 sync cycles.
- RX_AVAIL drops the cycle after the popping fall when the last byte is read.

## Structure
- Package usb_uart_pkg: status bit positions (ST_RXAVAIL=0, ST_TXREADY=1, ST_OVERRUN=2, ST_FRAMERR=3) and the shared 2-bit state encoding (IDLE, START, DATA, STOP).
- Sub-module usb_rx_fifo: synchronous FIFO (push, pop, head, empty, full, parameter DEPTH).
- The TX and RX engines stay in usb_uart_port.

## Test plan
All scenarios use CLKS_PER_BIT=8.
- Write 8'hA5 on usbtxd_cs (3 cycles high) -> usb_txd: 0, 1,0,1,0,0,1,0,1, 1, each 8 cycles. TX_READY reads 1 again 3 cycles after the write edge. Exactly one frame is sent.
- Two back-to-back writes 8'h55, 8'hAA -> two contiguous 80-cycle frames with no idle bits. A third write while holding is full is dropped, so only two frames are sent.
- Drive frame 8'h3C on usb_rxd -> status reads 8'h03. The data read returns 8'h3C for the whole select. The next status read gives 8'h02.
- Send 17 bytes 0x00..0x10 with no reads (RX_DEPTH=16) -> status 8'h07. A status re-read gives 8'h03. Sixteen reads return 0x00..0x0F; the 17th read returns 8'h00.
- RX frame with low stop bit -> status 8'h0A, FIFO empty. A 3-cycle low glitch on usb_rxd -> no byte, no flags.
- Assert reset_n low mid-TX frame at bit 4 -> usb_txd high immediately. After release, status = 8'h02 and no frame resumes.
